seq_stage_controller: RTL and testbench

Sequencing controller for the single-cycle-datapath Y86-64 SEQ core. Steps the Fetch, Decode_Writeback and Execute units (plus data memory) through one stage per clock and owns the architectural PC. It selects the next PC from valP/valC/valM and gates condition-code writes. It tracks the Y86 status code (AOK/HLT/ADR/INS) and counts retired instructions.

---
 rtl/seq_stage_controller.sv | 198 +++++++++++++++++++
 tb/tb_seq_stage_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_stage_controller.sv
`default_nettype none
// ============================================================================
// Module  : seq_stage_controller
// Brief   : Y86-64 SEQ sequencer: stage strobes, PC select, Stat, retire count
// Revision: 1.0 - initial release
// ============================================================================
module seq_stage_controller #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          MEM_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [3:0]  icode,
    input  logic        Condition,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [63:0] valM,
    input  logic        INS,
    input  logic        ADR,
    input  logic        HLT,
    input  logic        DmemErr,
    input  logic        MemAck,
    output logic [63:0] PC,
    output logic        FetchEn,
    output logic        DecodeEn,
    output logic        ExecEn,
    output logic        WbEn,
    output logic        MemReq,
    output logic        CCWrite,
    output logic [2:0]  Stat,
    output logic        Busy,
    output logic [31:0] Retired
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXECUTE   = 4'd3,
        S_MEMORY    = 4'd4,
        S_WRITEBACK = 4'd5,
        S_PCUPD     = 4'd6,
        S_HALTED    = 4'd7,
        S_FAULT     = 4'd8
    } state_t;

    localparam logic [2:0] c_stat_aok = 3'd1;
    localparam logic [2:0] c_stat_hlt = 3'd2;
    localparam logic [2:0] c_stat_adr = 3'd3;
    localparam logic [2:0] c_stat_ins = 3'd4;
    // Last wait-count value before the timeout fires; MEMORY lasts MEM_TIMEOUT cycles.
    localparam logic [7:0] c_wait_last = 8'(MEM_TIMEOUT - 1);

    state_t      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_valm;
    logic [3:0]  r_icode;
    logic [7:0]  r_wait;
    logic [31:0] r_retired;
    logic [2:0]  r_stat;
    logic        r_fetch_en, r_decode_en, r_exec_en, r_wb_en, r_mem_req;
    logic        r_cc_write, r_busy;
    logic        w_is_mem;
    logic [63:0] w_next_pc;

    always_comb begin
        w_is_mem = 1'b0;
        case (r_icode)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: w_is_mem = 1'b1;
            default:                            w_is_mem = 1'b0;
        endcase
    end

    always_comb begin
        w_next_pc = valP;
        if (r_icode == 4'h8 || (r_icode == 4'h7 && Condition))
            w_next_pc = valC;
        else if (r_icode == 4'h9)
            w_next_pc = r_valm;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_valm      <= 64'h0;
            r_icode     <= 4'h0;
            r_wait      <= 8'h0;
            r_retired   <= 32'h0;
            r_stat      <= c_stat_aok;
            r_fetch_en  <= 1'b0;
            r_decode_en <= 1'b0;
            r_exec_en   <= 1'b0;
            r_wb_en     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_cc_write  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Strobes are single-cycle; each transition raises the one for its target.
            r_fetch_en  <= 1'b0;
            r_decode_en <= 1'b0;
            r_exec_en   <= 1'b0;
            r_wb_en     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_cc_write  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_state    <= S_FETCH;
                        r_fetch_en <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_icode <= icode;
                    if (ADR) begin
                        r_state <= S_FAULT;
                        r_stat  <= c_stat_adr;
                        r_busy  <= 1'b0;
                    end else if (INS) begin
                        r_state <= S_FAULT;
                        r_stat  <= c_stat_ins;
                        r_busy  <= 1'b0;
                    end else if (HLT) begin
                        r_state   <= S_HALTED;
                        r_stat    <= c_stat_hlt;
                        r_retired <= r_retired + 32'd1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_state     <= S_DECODE;
                        r_decode_en <= 1'b1;
                    end
                end
                S_DECODE: begin
                    r_state    <= S_EXECUTE;
                    r_exec_en  <= 1'b1;
                    r_cc_write <= (r_icode == 4'h6);
                end
                S_EXECUTE: begin
                    if (w_is_mem) begin
                        r_state   <= S_MEMORY;
                        r_mem_req <= 1'b1;
                        r_wait    <= 8'h0;
                    end else begin
                        r_state <= S_WRITEBACK;
                        r_wb_en <= 1'b1;
                    end
                end
                S_MEMORY: begin
                    if (MemAck) begin
                        if (DmemErr) begin
                            r_state <= S_FAULT;
                            r_stat  <= c_stat_adr;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_WRITEBACK;
                            r_wb_en <= 1'b1;
                            r_valm  <= valM;
                        end
                    end else if (r_wait == c_wait_last) begin
                        r_state <= S_FAULT;
                        r_stat  <= c_stat_adr;
                        r_busy  <= 1'b0;
                    end else begin
                        r_wait    <= r_wait + 8'd1;
                        r_mem_req <= 1'b1;
                    end
                end
                S_WRITEBACK: r_state <= S_PCUPD;
                S_PCUPD: begin
                    r_pc       <= w_next_pc;
                    r_retired  <= r_retired + 32'd1;
                    r_state    <= S_FETCH;
                    r_fetch_en <= 1'b1;
                end
                S_HALTED, S_FAULT: r_state <= r_state;
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign PC       = r_pc;
    assign FetchEn  = r_fetch_en;
    assign DecodeEn = r_decode_en;
    assign ExecEn   = r_exec_en;
    assign WbEn     = r_wb_en;
    assign MemReq   = r_mem_req;
    assign CCWrite  = r_cc_write;
    assign Stat     = r_stat;
    assign Busy     = r_busy;
    assign Retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_seq_stage_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_stage_controller
// Brief   : Directed + randomized bench for seq_stage_controller
// Revision: 1.0 - initial release
// ============================================================================
module tb_seq_stage_controller;

    localparam logic [63:0] c_reset_pc = 64'hA0;
    localparam int          c_tmo      = 15;

    logic        Clk = 1'b0;
    logic        Reset_n, Start, Condition, INS, ADR, HLT, DmemErr, MemAck;
    logic [3:0]  icode;
    logic [63:0] valC, valP, valM, PC;
    logic        FetchEn, DecodeEn, ExecEn, WbEn, MemReq, CCWrite, Busy;
    logic [2:0]  Stat;
    logic [31:0] Retired;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_pc;
    logic [31:0] exp_ret;
    logic        term;

    seq_stage_controller #(.RESET_PC(c_reset_pc), .MEM_TIMEOUT(c_tmo)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .icode(icode),
        .Condition(Condition), .valC(valC), .valP(valP), .valM(valM),
        .INS(INS), .ADR(ADR), .HLT(HLT), .DmemErr(DmemErr), .MemAck(MemAck),
        .PC(PC), .FetchEn(FetchEn), .DecodeEn(DecodeEn), .ExecEn(ExecEn),
        .WbEn(WbEn), .MemReq(MemReq), .CCWrite(CCWrite), .Stat(Stat),
        .Busy(Busy), .Retired(Retired)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        chk({tag, "_pc"}, PC, c_reset_pc);
        chk({tag, "_ret"}, 64'(Retired), 64'd0);
        chk({tag, "_stat"}, 64'(Stat), 64'd1);
        chk({tag, "_strobes"}, 64'({FetchEn, DecodeEn, ExecEn, WbEn, MemReq, CCWrite, Busy}), 64'd0);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0; Start = 1'b0; MemAck = 1'b0; DmemErr = 1'b0;
        INS = 1'b0; ADR = 1'b0; HLT = 1'b0;
        repeat (2) @(negedge Clk);
        check_idle_reset("reset");
        Reset_n = 1'b1;
        @(negedge Clk);
        exp_pc  = c_reset_pc;
        exp_ret = 32'd0;
    endtask

    task automatic start_run();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("start_fetch", 64'(FetchEn), 64'd1);
    endtask

    // Runs one instruction from its FETCH cycle. dly = MemAck-low cycles (>= c_tmo means never).
    // flg = {ADR, INS, HLT}. Expected behaviour comes from the instruction-level rules.
    task automatic run_instr(input logic [3:0] ic, input logic cond, input logic [63:0] c,
                             input logic [63:0] p, input logic [63:0] m, input int dly,
                             input logic derr, input logic [2:0] flg, output logic terminal);
        int   cyc = 0, nmem = 0, ncc = 0;
        int   e_cyc, e_mem;
        logic multi = 1'b0, is_mem;
        logic [2:0]  e_stat;
        logic [63:0] nxt;
        icode = ic; Condition = cond; valC = c; valP = p; valM = m;
        {ADR, INS, HLT} = flg;
        for (int i = 0; i < 60; i++) begin
            if (MemReq) begin
                MemAck  = (nmem == dly);
                DmemErr = derr;
                nmem++;
            end else begin
                MemAck  = 1'($urandom_range(0, 1));
                DmemErr = 1'($urandom_range(0, 1));
            end
            ncc += int'(CCWrite);
            if ((int'(FetchEn) + int'(DecodeEn) + int'(ExecEn) + int'(WbEn) + int'(MemReq)) > 1)
                multi = 1'b1;
            @(negedge Clk);
            cyc++;
            if (FetchEn || !Busy) break;
        end
        {ADR, INS, HLT} = 3'b000;
        MemAck = 1'b0;

        is_mem   = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        e_stat   = 3'd1;
        e_mem    = 0;
        terminal = 1'b1;
        if (flg[2]) begin
            e_cyc = 1; e_stat = 3'd3;
        end else if (flg[1]) begin
            e_cyc = 1; e_stat = 3'd4;
        end else if (flg[0]) begin
            e_cyc = 1; e_stat = 3'd2; exp_ret = exp_ret + 32'd1;
        end else if (is_mem && dly >= c_tmo) begin
            e_mem = c_tmo; e_cyc = 3 + c_tmo; e_stat = 3'd3;
        end else if (is_mem && derr) begin
            e_mem = dly + 1; e_cyc = 3 + dly + 1; e_stat = 3'd3;
        end else begin
            terminal = 1'b0;
            e_mem    = is_mem ? dly + 1 : 0;
            e_cyc    = is_mem ? 6 + dly : 5;
            if (ic == 4'h8 || (ic == 4'h7 && cond)) nxt = c;
            else if (ic == 4'h9)                     nxt = m;
            else                                     nxt = p;
            exp_pc  = nxt;
            exp_ret = exp_ret + 32'd1;
        end
        chk("cycles", 64'(cyc), 64'(e_cyc));
        chk("memreq_cycles", 64'(nmem), 64'(e_mem));
        chk("ccwrite", 64'(ncc), (!flg && ic == 4'h6) ? 64'd1 : 64'd0);
        chk("onehot", 64'(multi), 64'd0);
        chk("pc", PC, exp_pc);
        chk("retired", 64'(Retired), 64'(exp_ret));
        chk("stat", 64'(Stat), 64'(e_stat));
        chk("busy", 64'(Busy), 64'(!terminal));
    endtask

    initial begin
        logic [3:0]  ric;
        logic [2:0]  rflg;
        int          rdly, sel;
        logic        rderr;
        icode = 4'h0; Condition = 1'b0; valC = '0; valP = '0; valM = '0;
        do_reset();
        start_run();

        // nop, taken/not-taken jump, ret with late ack
        run_instr(4'h1, 1'b0, 64'h0, 64'h2, 64'h0, 0, 1'b0, 3'b000, term);
        chk("nop_pc", PC, 64'h2);
        run_instr(4'h7, 1'b1, 64'h100, 64'h77, 64'h0, 0, 1'b0, 3'b000, term);
        chk("jxx_taken", PC, 64'h100);
        run_instr(4'h7, 1'b0, 64'h100, 64'h9, 64'h0, 0, 1'b0, 3'b000, term);
        chk("jxx_not_taken", PC, 64'h9);
        run_instr(4'h6, 1'b1, 64'h55, 64'h0B, 64'h0, 0, 1'b0, 3'b000, term);
        run_instr(4'h9, 1'b0, 64'h33, 64'h44, 64'h40, 3, 1'b0, 3'b000, term);
        chk("ret_pc", PC, 64'h40);
        run_instr(4'h8, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h50, 64'h0, 0, 1'b0, 3'b000, term);

        // Async reset mid-MEMORY
        icode = 4'h5;
        for (int i = 0; i < 10 && !MemReq; i++) @(negedge Clk);
        chk("reached_memory", 64'(MemReq), 64'd1);
        #2 Reset_n = 1'b0;
        #1 check_idle_reset("async_reset");
        do_reset();
        start_run();

        // Memory timeout
        run_instr(4'h1, 1'b0, 64'h0, 64'h20, 64'h0, 0, 1'b0, 3'b000, term);
        run_instr(4'h5, 1'b0, 64'h0, 64'h30, 64'h0, 255, 1'b0, 3'b000, term);
        chk("timeout_term", 64'(term), 64'd1);

        // ADR+INS together, then halt with Start ignored
        do_reset(); start_run();
        run_instr(4'h1, 1'b0, 64'h0, 64'h2, 64'h0, 0, 1'b0, 3'b110, term);
        do_reset(); start_run();
        run_instr(4'h0, 1'b0, 64'h0, 64'h1, 64'h0, 0, 1'b0, 3'b001, term);
        Start = 1'b1;
        repeat (3) @(negedge Clk);
        Start = 1'b0;
        chk("halt_start_ignored", 64'({FetchEn, Busy}), 64'd0);
        chk("halt_stat_hold", 64'(Stat), 64'd2);
        chk("halt_ret_hold", 64'(Retired), 64'd1);

        // Randomized instruction stream
        do_reset(); start_run();
        for (int k = 0; k < 80; k++) begin
            ric   = 4'($urandom_range(0, 11));
            sel   = $urandom_range(0, 24);
            rflg  = (sel < 4) ? 3'(sel) : 3'b000;
            if (sel == 3) rflg = 3'($urandom_range(1, 7));
            sel   = $urandom_range(0, 9);
            rdly  = (sel == 9) ? 255 : (sel % 5);
            rderr = (sel == 8);
            run_instr(ric, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                      {$urandom, $urandom}, rdly, rderr, rflg, term);
            if (term) begin
                do_reset();
                start_run();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL global_timeout observed=running expected=finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
